// File: rtl/peripheral_gpio_input_filter_pkg.sv
// Defaults shared between the GPIO input conditioning stage and the APB4 GPIO slave.
package peripheral_gpio_pkg;
  localparam int GPIO_PDATA_SIZE = 32;
  localparam int GPIO_SYNC_DEPTH = 3;
  localparam int GPIO_FILTER_LEN = 4;
  localparam int GPIO_PRESCALE_W = 16;
endpackage

// File: rtl/peripheral_gpio_input_filter_if.sv
// Pad, control and status bundle between the GPIO register block and the input filter.
interface peripheral_gpio_input_filter_if
  import peripheral_gpio_pkg::*;
#(
  parameter int PDATA_SIZE = GPIO_PDATA_SIZE,
  parameter int PRESCALE_W = GPIO_PRESCALE_W
);
  logic [PDATA_SIZE-1:0] pad_i;
  logic [PRESCALE_W-1:0] prescale_i;
  logic [PDATA_SIZE-1:0] filter_en_i;
  logic [PDATA_SIZE-1:0] rise_en_i;
  logic [PDATA_SIZE-1:0] fall_en_i;
  logic [PDATA_SIZE-1:0] irq_clr_i;
  logic [PDATA_SIZE-1:0] gpio_o;
  logic [PDATA_SIZE-1:0] rise_o;
  logic [PDATA_SIZE-1:0] fall_o;
  logic [PDATA_SIZE-1:0] irq_pending_o;
  logic                  irq_o;

  modport master (
    output pad_i, prescale_i, filter_en_i, rise_en_i, fall_en_i, irq_clr_i,
    input  gpio_o, rise_o, fall_o, irq_pending_o, irq_o
  );

  modport slave (
    input  pad_i, prescale_i, filter_en_i, rise_en_i, fall_en_i, irq_clr_i,
    output gpio_o, rise_o, fall_o, irq_pending_o, irq_o
  );
endinterface

// File: rtl/peripheral_gpio_filter_bit.sv
// One GPIO bit: synchronizer, tick-sampled glitch filter, stable level and edge pulses.
module peripheral_gpio_filter_bit
  import peripheral_gpio_pkg::*;
#(
  parameter int SYNC_DEPTH = GPIO_SYNC_DEPTH,
  parameter int FILTER_LEN = GPIO_FILTER_LEN
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic pad_i,
  input  logic tick_i,
  input  logic filter_en_i,
  output logic gpio_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_DEPTH-1:0] sync_q;
  logic [FILTER_LEN-1:0] shift_q;
  logic                  stable_q;
  logic                  prev_q;
  logic                  synced;

  assign synced = sync_q[SYNC_DEPTH-1];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_q   <= '0;
      shift_q  <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], pad_i};
      // Sampling continues in bypass so switching to filtered mode starts from real history.
      if (tick_i) shift_q <= {shift_q[FILTER_LEN-2:0], synced};
      if (!filter_en_i)       stable_q <= synced;
      else if (&shift_q)      stable_q <= 1'b1;
      else if (~|shift_q)     stable_q <= 1'b0;
      prev_q <= stable_q;
    end
  end

  assign gpio_o = stable_q;
  assign rise_o = stable_q & ~prev_q;
  assign fall_o = ~stable_q & prev_q;
endmodule

// File: rtl/peripheral_gpio_input_filter.sv
// GPIO input conditioning: shared sample prescaler, per-bit filters, sticky edge pending flags.
module peripheral_gpio_input_filter
  import peripheral_gpio_pkg::*;
#(
  parameter int PDATA_SIZE = GPIO_PDATA_SIZE,
  parameter int SYNC_DEPTH = GPIO_SYNC_DEPTH,
  parameter int FILTER_LEN = GPIO_FILTER_LEN,
  parameter int PRESCALE_W = GPIO_PRESCALE_W
) (
  input logic PCLK,
  input logic PRESETn,
  peripheral_gpio_input_filter_if.slave bus
);
  logic [PRESCALE_W-1:0] cnt;
  logic                  tick;
  logic [PDATA_SIZE-1:0] gpio;
  logic [PDATA_SIZE-1:0] rise;
  logic [PDATA_SIZE-1:0] fall;
  logic [PDATA_SIZE-1:0] pending_q;

  // >= rather than == so lowering prescale below cnt ticks at once instead of wrapping.
  assign tick = (cnt >= bus.prescale_i);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  for (genvar i = 0; i < PDATA_SIZE; i++) begin : g_bit
    peripheral_gpio_filter_bit #(
      .SYNC_DEPTH (SYNC_DEPTH),
      .FILTER_LEN (FILTER_LEN)
    ) u_bit (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .pad_i       (bus.pad_i[i]),
      .tick_i      (tick),
      .filter_en_i (bus.filter_en_i[i]),
      .gpio_o      (gpio[i]),
      .rise_o      (rise[i]),
      .fall_o      (fall[i])
    );
  end

  // Set has priority over clear so an edge arriving with the clear pulse is not lost.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) pending_q <= '0;
    else          pending_q <= (rise & bus.rise_en_i) | (fall & bus.fall_en_i)
                             | (pending_q & ~bus.irq_clr_i);
  end

  assign bus.gpio_o        = gpio;
  assign bus.rise_o        = rise;
  assign bus.fall_o        = fall;
  assign bus.irq_pending_o = pending_q;
  assign bus.irq_o         = |pending_q;
endmodule

// File: tb/tb_peripheral_gpio_input_filter.sv
// Directed bench for the GPIO input filter: reset, bypass, glitch, prescaler, pending, mid-filter reset.
module tb_peripheral_gpio_input_filter;
  logic PCLK;
  logic PRESETn;
  int total;
  int bad;

  peripheral_gpio_input_filter_if #(.PDATA_SIZE(32), .PRESCALE_W(16)) gif ();

  peripheral_gpio_input_filter #(
    .PDATA_SIZE (32),
    .SYNC_DEPTH (3),
    .FILTER_LEN (4),
    .PRESCALE_W (16)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (gif)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    gif.pad_i = 32'hFFFF_FFFF;
    gif.prescale_i = '0;
    gif.filter_en_i = '0;
    gif.rise_en_i = '0;
    gif.fall_en_i = '0;
    gif.irq_clr_i = '0;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({gif.gpio_o, gif.rise_o, gif.irq_pending_o, gif.irq_o} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got gpio=%h rise=%h pend=%h irq=%b want all 0",
                 gif.gpio_o, gif.rise_o, gif.irq_pending_o, gif.irq_o);
      end
    end
    PRESETn = 1'b1;
    repeat (3) step();
    total++;
    if (gif.gpio_o !== 32'h0) begin
      bad++; $display("FAIL reset_early: got gpio=%h want 00000000", gif.gpio_o);
    end
    step();
    total++;
    if (gif.gpio_o !== 32'hFFFF_FFFF || gif.rise_o !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL reset_release: got gpio=%h rise=%h want ffffffff ffffffff", gif.gpio_o, gif.rise_o);
    end
    step();
    total++;
    if (gif.rise_o !== 32'h0 || gif.irq_o !== 1'b0) begin
      bad++; $display("FAIL reset_rise_once: got rise=%h irq=%b want 0 0", gif.rise_o, gif.irq_o);
    end
  endtask

  task automatic test_bypass();
    gif.pad_i = '0;
    repeat (6) step();
    gif.rise_en_i = 32'h1;
    gif.pad_i[0] = 1'b1;
    repeat (3) step();
    total++;
    if (gif.gpio_o[0] !== 1'b0) begin
      bad++; $display("FAIL bypass_early: got gpio0=%b want 0", gif.gpio_o[0]);
    end
    step();
    total++;
    if (gif.gpio_o[0] !== 1'b1 || gif.rise_o[0] !== 1'b1 || gif.irq_pending_o[0] !== 1'b0) begin
      bad++; $display("FAIL bypass_edge: got gpio0=%b rise0=%b pend0=%b want 1 1 0",
                      gif.gpio_o[0], gif.rise_o[0], gif.irq_pending_o[0]);
    end
    step();
    total++;
    if (gif.rise_o[0] !== 1'b0 || gif.irq_pending_o[0] !== 1'b1 || gif.irq_o !== 1'b1) begin
      bad++; $display("FAIL bypass_pending: got rise0=%b pend0=%b irq=%b want 0 1 1",
                      gif.rise_o[0], gif.irq_pending_o[0], gif.irq_o);
    end
    gif.rise_en_i = '0;
  endtask

  task automatic test_glitch();
    int seen;
    gif.filter_en_i = 32'h0000_0020;
    gif.prescale_i = '0;
    gif.pad_i[5] = 1'b1;
    repeat (3) step();
    gif.pad_i[5] = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (gif.gpio_o[5] !== 1'b0 || gif.rise_o[5] !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL glitch_reject: got %0d cycles with gpio5/rise5 set want 0", seen);
    end
    gif.pad_i[5] = 1'b1;
    repeat (7) step();
    total++;
    if (gif.gpio_o[5] !== 1'b0) begin
      bad++; $display("FAIL filter_early: got gpio5=%b want 0", gif.gpio_o[5]);
    end
    step();
    total++;
    if (gif.gpio_o[5] !== 1'b1 || gif.rise_o[5] !== 1'b1) begin
      bad++; $display("FAIL filter_accept: got gpio5=%b rise5=%b want 1 1", gif.gpio_o[5], gif.rise_o[5]);
    end
  endtask

  task automatic test_prescaled();
    gif.prescale_i = 16'd9;
    gif.filter_en_i[2] = 1'b1;
    gif.pad_i[2] = 1'b1;
    repeat (40) step();
    total++;
    if (gif.gpio_o[2] !== 1'b0) begin
      bad++; $display("FAIL presc_early: got gpio2=%b want 0", gif.gpio_o[2]);
    end
    step();
    total++;
    if (gif.gpio_o[2] !== 1'b1 || gif.rise_o[2] !== 1'b1) begin
      bad++; $display("FAIL presc_accept: got gpio2=%b rise2=%b want 1 1", gif.gpio_o[2], gif.rise_o[2]);
    end
    repeat (6) step();
    total++;
    if (dut.cnt !== 16'd7 || dut.tick !== 1'b0) begin
      bad++; $display("FAIL presc_cnt: got cnt=%0d tick=%b want 7 0", dut.cnt, dut.tick);
    end
    gif.prescale_i = 16'd2;
    #1;
    total++;
    if (dut.tick !== 1'b1) begin
      bad++; $display("FAIL presc_lower_tick: got tick=%b want 1", dut.tick);
    end
    step();
    total++;
    if (dut.cnt !== 16'd0) begin
      bad++; $display("FAIL presc_lower_cnt: got cnt=%0d want 0", dut.cnt);
    end
    gif.prescale_i = '0;
    repeat (2) step();
  endtask

  task automatic test_collision();
    gif.irq_clr_i = 32'hFFFF_FFFF;
    step();
    gif.irq_clr_i = '0;
    total++;
    if (gif.irq_pending_o !== 32'h0 || gif.irq_o !== 1'b0) begin
      bad++; $display("FAIL clear_all: got pend=%h irq=%b want 0 0", gif.irq_pending_o, gif.irq_o);
    end
    gif.rise_en_i[7] = 1'b1;
    gif.pad_i[7] = 1'b1;
    repeat (5) step();
    total++;
    if (gif.irq_pending_o !== 32'h0000_0080) begin
      bad++; $display("FAIL coll_setup: got pend=%h want 00000080", gif.irq_pending_o);
    end
    gif.fall_en_i[7] = 1'b1;
    gif.pad_i[7] = 1'b0;
    repeat (4) step();
    total++;
    if (gif.fall_o[7] !== 1'b1) begin
      bad++; $display("FAIL coll_fall: got fall7=%b want 1", gif.fall_o[7]);
    end
    gif.irq_clr_i[7] = 1'b1;
    step();
    gif.irq_clr_i = '0;
    total++;
    if (gif.irq_pending_o[7] !== 1'b1 || gif.fall_o[7] !== 1'b0) begin
      bad++; $display("FAIL coll_set_wins: got pend7=%b fall7=%b want 1 0", gif.irq_pending_o[7], gif.fall_o[7]);
    end
    gif.rise_en_i = '0;
    gif.fall_en_i = '0;
    step();
    total++;
    if (gif.irq_pending_o[7] !== 1'b1) begin
      bad++; $display("FAIL coll_en_off_hold: got pend7=%b want 1", gif.irq_pending_o[7]);
    end
    gif.irq_clr_i[7] = 1'b1;
    step();
    gif.irq_clr_i = '0;
    total++;
    if (gif.irq_pending_o !== 32'h0 || gif.irq_o !== 1'b0) begin
      bad++; $display("FAIL coll_clear: got pend=%h irq=%b want 0 0", gif.irq_pending_o, gif.irq_o);
    end
  endtask

  task automatic test_mid_reset();
    gif.pad_i = '0;
    gif.filter_en_i = 32'h0000_0008;
    repeat (10) step();
    gif.pad_i[3] = 1'b1;
    repeat (5) step();
    PRESETn = 1'b0;
    #1;
    total++;
    if (gif.gpio_o !== 32'h0 || gif.irq_o !== 1'b0) begin
      bad++; $display("FAIL midrst_async: got gpio=%h irq=%b want 0 0", gif.gpio_o, gif.irq_o);
    end
    repeat (2) step();
    PRESETn = 1'b1;
    repeat (7) step();
    total++;
    if (gif.gpio_o[3] !== 1'b0) begin
      bad++; $display("FAIL midrst_early: got gpio3=%b want 0", gif.gpio_o[3]);
    end
    step();
    total++;
    if (gif.gpio_o[3] !== 1'b1 || gif.rise_o[3] !== 1'b1) begin
      bad++; $display("FAIL midrst_accept: got gpio3=%b rise3=%b want 1 1", gif.gpio_o[3], gif.rise_o[3]);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_bypass();
    test_glitch();
    test_prescaled();
    test_collision();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/peripheral_gpio_input_filter.md
Name: peripheral_gpio_input_filter

Overview:
Input-conditioning stage directly upstream of the GPIO APB4 slave: raw asynchronous pad inputs in, clean synchronized levels out to the slave's gpio_i.
- Synchronizes each bit, with an optional per-bit glitch filter clocked by a shared programmable sample tick.
- Detects rising/falling edges and keeps per-bit sticky interrupt-pending flags.
- Control inputs are driven from GPIO slave registers.

Parameters:
PDATA_SIZE, 32, number of GPIO bits
SYNC_DEPTH, 3, synchronizer flop stages (>=2)
FILTER_LEN, 4, consecutive equal samples required to accept a new level (>=2)
PRESCALE_W, 16, width of sample-tick prescaler

Ports:
PCLK  input  1  clock
PRESETn  input  1  reset; asynchronous assert, active-low
pad_i  input  PDATA_SIZE  raw asynchronous pad levels
prescale_i  input  PRESCALE_W  sample tick every prescale_i+1 cycles
filter_en_i  input  PDATA_SIZE  1 = bit filtered, 0 = bypass (sync only)
rise_en_i  input  PDATA_SIZE  rising edge sets pending
fall_en_i  input  PDATA_SIZE  falling edge sets pending
irq_clr_i  input  PDATA_SIZE  one-cycle clear pulses for pending bits
gpio_o  output  PDATA_SIZE  conditioned level, feeds slave gpio_i
rise_o  output  PDATA_SIZE  one-cycle rising-edge pulse
fall_o  output  PDATA_SIZE  one-cycle falling-edge pulse
irq_pending_o  output  PDATA_SIZE  sticky pending flags
irq_o  output  1  OR of irq_pending_o

Behaviour:
Reset (PRESETn low, asynchronous):
- All flops clear to 0.
- gpio_o, rise_o, fall_o, irq_pending_o and irq_o all read 0.
- No edge is reported on the first cycles after reset if the pad is low.
- Reset mid-filter discards partial samples.

Synchronizer:
- SYNC_DEPTH-flop chain per bit, clocked every cycle.
- Only the last stage is used downstream.

Prescaler:
- Counter cnt. tick = (cnt >= prescale_i).
- On tick, cnt <= 0; otherwise cnt <= cnt+1.
- prescale_i = 0 gives a tick every cycle.
- Lowering prescale_i below cnt produces a tick on the next cycle (no 2^PRESCALE_W wrap).

Filter, per bit:
- FILTER_LEN-bit shift register loads the synced bit on every tick, whatever filter_en is.
- Filtered mode: the stable register takes the new value in the cycle after a tick where all FILTER_LEN samples are equal.
- Bypass mode: the stable register follows the synced bit every cycle.
- Toggling filter_en_i takes effect immediately. No spurious edge results unless stable actually changes.
- gpio_o = stable register.

Latency, pad change to gpio_o:
- Bypass: SYNC_DEPTH+1 cycles.
- Filtered with prescale 0: SYNC_DEPTH+FILTER_LEN+1 cycles.
- Pulses shorter than FILTER_LEN ticks never reach gpio_o.

Edges:
- Register prev <= gpio_o.
- rise_o = gpio_o & ~prev; fall_o = ~gpio_o & prev.
- Pulses are combinational, asserted in the first cycle gpio_o shows the new level, for exactly one cycle.

Pending, per bit, at the next clock edge:
- Set if (rise_o & rise_en_i) | (fall_o & fall_en_i).
- Else clear if irq_clr_i.
- Else hold.
- Set and clear in the same cycle: set wins.
- Disabling rise_en/fall_en does not clear an existing pending bit.

irq_o: combinational OR of pending bits.

No handshake: all outputs are valid every cycle.

Decomposition:
- Package peripheral_gpio_pkg holds the defaults for SYNC_DEPTH, FILTER_LEN and PRESCALE_W, shared with the APB4 GPIO slave.
- Sub-module peripheral_gpio_filter_bit holds one bit's synchronizer, shift register and stable/prev flops, plus the rise/fall outputs.
- Top contains the shared prescaler, the generate loop over PDATA_SIZE, pending flags and irq_o.

Test Plan:
1. Reset: PRESETn low for 3 cycles with pad_i=32'hFFFF_FFFF, filter_en=0 -> all outputs 0 during reset. gpio_o=32'hFFFF_FFFF exactly 4 cycles after release; rise_o=32'hFFFF_FFFF for that one cycle.
2. Bypass latency: filter_en=0, pad_i[0] 0->1 -> gpio_o[0] rises after 4 cycles. rise_o[0] high 1 cycle. With rise_en[0]=1, irq_pending_o[0] and irq_o set the following cycle.
3. Glitch rejection: filter_en[5]=1, prescale=0, pad_i[5] high for 3 cycles then low -> gpio_o[5] stays 0 and rise_o[5] never asserts. High for 4+ cycles -> gpio_o[5]=1 after 8 cycles.
4. Prescaled filter: prescale=9, filter_en[2]=1, pad_i[2] held high -> ticks every 10 cycles; gpio_o[2] rises within 4 ticks (<=43 cycles). Writing prescale=2 while cnt=7 -> tick on the next cycle.
5. Set/clear collision: fall_en[7]=1, pending[7] already 1; irq_clr[7] pulses in the same cycle as fall_o[7] -> pending[7] stays 1. A later irq_clr[7] alone -> pending[7]=0, irq_o=0.
6. Mid-filter reset: assert PRESETn low while pad_i[3] sequence is 2/4 accepted -> after release, counting restarts. gpio_o[3] follows only after a full SYNC_DEPTH+FILTER_LEN+1 cycles.
